// File: rtl/instruction_mem_pkg.sv
// Shared constants and boot image for the instruction store.
package instruction_mem_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned BOOT_LEN = 11;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t NOP_WORD = 32'h0000_0013;

    // Boot program image; entries past the program are filled with NOP.
    function automatic word_t boot_word(input int unsigned idx);
        word_t w;
        w = NOP_WORD;
        case (idx)
            0:       w = 32'h0050_0093;
            1:       w = 32'h00A0_0113;
            2:       w = 32'h0020_81B3;
            3:       w = 32'h4020_8233;
            4:       w = 32'h0020_F2B3;
            5:       w = 32'h0020_E333;
            6:       w = 32'h0020_C3B3;
            7:       w = 32'h0030_2023;
            8:       w = 32'h0000_2403;
            9:       w = 32'h0084_0463;
            10:      w = 32'h0000_0013;
            default: w = NOP_WORD;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instruction_mem.sv
// Word-addressed instruction store: combinational read for fetch,
// synchronous write port, boot image reloaded on synchronous reset.
module instruction_mem
    import instruction_mem_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned ADDR_BITS = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] address,
    output logic [WORD_W-1:0] instruction,
    output logic              addr_err,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data
);

    word_t mem [DEPTH];

    logic rd_in_range;
    logic wr_in_range;

    // Full-width compares so any set upper bit rejects the access; no aliasing.
    assign rd_in_range = (address < WORD_W'(DEPTH));
    assign wr_in_range = (wr_addr < WORD_W'(DEPTH));

    // Zero-latency read mux.
    always_comb begin
        instruction = NOP_WORD;
        addr_err    = 1'b1;
        if (rd_in_range) begin
            instruction = mem[address[ADDR_BITS-1:0]];
            addr_err    = 1'b0;
        end
    end

    // Reset wins over a same-cycle write; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_BITS'(i)] <= boot_word(i);
            end
        end else if (wr_en && wr_in_range) begin
            mem[wr_addr[ADDR_BITS-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_instruction_mem.sv
// Self-checking bench for instruction_mem: spec-level memory model plus
// directed vectors with hand-computed expectations.
module tb_instruction_mem;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic [31:0] address;
    logic [31:0] instruction;
    logic        addr_err;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    int checks = 0;
    int passes = 0;

    instruction_mem #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .instruction (instruction),
        .addr_err    (addr_err),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] boot_img [11] = '{
        32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h4020_8233,
        32'h0020_F2B3, 32'h0020_E333, 32'h0020_C3B3, 32'h0030_2023,
        32'h0000_2403, 32'h0084_0463, 32'h0000_0013
    };

    // Behavioural model: plain array updated by the write/reset rules.
    logic [31:0] model [DEPTH];
    bit          model_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++)
                model[i] = (i < 11) ? boot_img[i] : NOP;
            model_valid = 1'b1;
        end else if (wr_en && wr_addr < DEPTH) begin
            model[wr_addr] = wr_data;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            logic [31:0] exp_instr;
            logic        exp_err;
            exp_err   = (address >= DEPTH);
            exp_instr = exp_err ? NOP : model[address];
            check($sformatf("model_instr@%h", address), instruction, exp_instr);
            check($sformatf("model_err@%h", address), 32'(addr_err), 32'(exp_err));
        end
    end

    task automatic drive(input logic r, input logic we, input logic [31:0] wa,
                         input logic [31:0] wd, input logic [31:0] a);
        reset   = r;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        address = a;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; address = '0;
        tick();

        // Reset state and boot image sweep
        drive(0, 0, 0, 0, 0);
        check("reset_word0", instruction, 32'h0050_0093);
        check("reset_err0", 32'(addr_err), 32'd0);
        for (int a = 0; a <= 10; a++) begin
            drive(0, 0, 0, 0, 32'(a));
            if (a == 2) check("boot_addr2", instruction, 32'h0020_81B3);
            if (a == 9) check("boot_addr9", instruction, 32'h0084_0463);
            tick();
        end

        // Range boundaries
        drive(0, 0, 0, 0, 32'd11);
        check("addr11_instr", instruction, NOP);
        check("addr11_err", 32'(addr_err), 32'd0);
        tick();
        drive(0, 0, 0, 0, 32'(DEPTH - 1));
        check("addr_last_instr", instruction, NOP);
        check("addr_last_err", 32'(addr_err), 32'd0);
        tick();
        drive(0, 0, 0, 0, 32'(DEPTH));
        check("addr_depth_instr", instruction, NOP);
        check("addr_depth_err", 32'(addr_err), 32'd1);
        tick();
        drive(0, 0, 0, 0, 32'hFFFF_FFFF);
        check("addr_max_instr", instruction, NOP);
        check("addr_max_err", 32'(addr_err), 32'd1);
        tick();

        // Read-during-write: old word before the edge, new word after
        drive(0, 1, 32'd3, 32'hDEAD_BEEF, 32'd3);
        check("rdw_before", instruction, 32'h4020_8233);
        tick();
        drive(0, 0, 0, 0, 32'd3);
        check("rdw_after", instruction, 32'hDEAD_BEEF);
        tick();

        // Write to last in-range index
        drive(0, 1, 32'(DEPTH - 1), 32'hA5A5_5A5A, 32'(DEPTH - 1));
        tick();
        drive(0, 0, 0, 0, 32'(DEPTH - 1));
        check("write_last", instruction, 32'hA5A5_5A5A);
        tick();

        // Out-of-range write is ignored; sweep relies on the model
        drive(0, 1, 32'(DEPTH + 5), 32'h1234_5678, 32'd5);
        tick();
        for (int a = 0; a < int'(DEPTH); a++) begin
            drive(0, 0, 0, 0, 32'(a));
            if (a == 3) check("oob_write_addr3", instruction, 32'hDEAD_BEEF);
            if (a == 5) check("oob_write_addr5", instruction, 32'h0020_E333);
            tick();
        end

        // Reset beats a same-cycle write
        drive(1, 1, 32'd0, 32'hCAFE_F00D, 32'd0);
        tick();
        drive(0, 0, 0, 0, 32'd0);
        check("reset_prio_word0", instruction, 32'h0050_0093);
        tick();
        drive(0, 0, 0, 0, 32'd3);
        check("reset_restore_word3", instruction, 32'h4020_8233);
        tick();
        drive(0, 0, 0, 0, 32'(DEPTH - 1));
        check("reset_restore_last", instruction, NOP);
        tick();

        // Overwrite words 0..4 with reset landing mid-sequence
        for (int a = 0; a < 5; a++) begin
            drive(a == 3, 1, 32'(a), 32'h1000_0000 + 32'(a), 32'(a));
            tick();
        end
        drive(0, 0, 0, 0, 32'd4);
        check("post_reset_word4_written", instruction, 32'h1000_0004);
        tick();
        for (int a = 0; a < 16; a++) begin
            drive(0, 0, 0, 0, 32'(a));
            if (a == 0) check("mid_reset_word0", instruction, 32'h0050_0093);
            if (a == 2) check("mid_reset_word2", instruction, 32'h0020_81B3);
            if (a == 3) check("mid_reset_word3", instruction, 32'h4020_8233);
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
